// File: rtl/circle_layer_mixer_pkg.sv
// -----------------------------------------------------------------------------
// circle_layer_mixer_pkg
//   Shared video definitions for the circle visualiser pixel back end:
//   colour/channel widths, idle levels of the VGA timing signals, the default
//   upstream pixel-generator latency, the brightness FSM state type and small
//   per-channel arithmetic helpers used by the mixer.
// -----------------------------------------------------------------------------
package circle_layer_mixer_pkg;

    localparam int COLOR_W     = 24;   // {R,G,B}
    localparam int CH_W        = 8;    // one colour channel
    localparam int NUM_CH      = 3;
    localparam int DEF_PIX_LAT = 3;    // pipeline depth of the circle generators

    // Idle levels: syncs are active-low, blank is active-high.
    localparam logic SYNC_IDLE  = 1'b1;
    localparam logic BLANK_IDLE = 1'b1;

    localparam logic [CH_W-1:0] BRIGHT_MAX = 8'hFF;

    // Brightness FSM: IDLE = no beat seen this frame, PENDING = a beat is
    // waiting for the next frame tick.
    typedef enum logic {
        BR_IDLE    = 1'b0,
        BR_PENDING = 1'b1
    } br_state_e;

    // Clamp a 10-bit channel sum (max 4*255) to 8 bits.
    function automatic logic [CH_W-1:0] sat_ch(input logic [9:0] sum);
        return (sum > 10'd255) ? 8'hFF : sum[7:0];
    endfunction

    // (ch * (bright+1)) >> 8. bright = 255 multiplies by 256, i.e. identity.
    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch,
                                                 input logic [CH_W-1:0] bright);
        logic [16:0] prod;
        prod = {9'd0, ch} * ({9'd0, bright} + 17'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/circle_layer_mixer_sync_delay_line.sv
// -----------------------------------------------------------------------------
// sync_delay_line
//   Fixed-depth shift register used to keep VGA timing signals aligned with a
//   pipelined pixel path. Every tap resets to RST_VAL so that after reset the
//   output shows idle timing for DEPTH cycles.
//
//   Ports:
//     clk    in   clock
//     reset  in   synchronous, active-high; loads RST_VAL into every tap
//     d_i    in   WIDTH  value entering the line
//     q_o    out  WIDTH  d_i delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module sync_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 5,   // must be >= 2
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // taps_q[i] holds d_i delayed by i+1 cycles.
    logic [DEPTH-1:0][WIDTH-1:0] taps_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            taps_q <= {DEPTH{RST_VAL}};
        end else begin
            taps_q <= {taps_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = taps_q[DEPTH-1];

endmodule

// File: rtl/circle_layer_mixer.sv
// -----------------------------------------------------------------------------
// circle_layer_mixer
//   Last pixel stage before the VGA DAC. Sums up to NUM_LAYERS circle layers
//   per channel with saturation (background colour when nothing is lit), then
//   scales by a frame-global brightness that jumps to full on an audio beat and
//   decays once per frame otherwise. Brightness only moves on the vsync falling
//   edge, so a frame is never drawn with two brightness levels.
//
//   Ports:
//     clk          in   pixel clock
//     reset        in   synchronous, active-high
//     hsync_in     in   active-low, aligned with hcount/vcount
//     vsync_in     in   active-low, aligned with hcount/vcount
//     blank_in     in   active-high, aligned with hcount/vcount
//     layer_pix    in   24*NUM_LAYERS, layer i at [24i+23:24i], PIX_LAT after syncs
//     layer_en     in   NUM_LAYERS per-layer enable
//     beat         in   single-cycle beat pulse
//     rgb_out      out  24 mixed, scaled pixel (0 while blanked)
//     hsync_out    out  hsync_in delayed PIX_LAT+2
//     vsync_out    out  vsync_in delayed PIX_LAT+2
//     blank_out    out  blank_in delayed PIX_LAT+2
//     brightness   out  8 current frame brightness
//     dbg_state_o  out  brightness FSM state (beat pending or not)
// -----------------------------------------------------------------------------
module circle_layer_mixer
    import circle_layer_mixer_pkg::*;
#(
    parameter int               NUM_LAYERS = 4,
    parameter int               PIX_LAT    = DEF_PIX_LAT,
    parameter int               DECAY      = 8,
    parameter int               MIN_BRIGHT = 32,
    parameter logic [COLOR_W-1:0] BG_COLOR = 24'h0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          blank_in,
    input  logic [COLOR_W*NUM_LAYERS-1:0] layer_pix,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic                          beat,
    output logic [COLOR_W-1:0]            rgb_out,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic                          blank_out,
    output logic [CH_W-1:0]               brightness,
    output br_state_e                     dbg_state_o
);

    localparam logic [CH_W-1:0] DECAY_B   = DECAY[CH_W-1:0];
    localparam logic [CH_W-1:0] MIN_B     = MIN_BRIGHT[CH_W-1:0];
    // Below this level a full decrement would cross the floor (or underflow).
    localparam logic [8:0]      FLOOR_THR = 9'(MIN_BRIGHT + DECAY);

    // ---------------------------------------------------------------- syncs
    // The pixel for a given sync sample arrives PIX_LAT later and spends two
    // more cycles in mix/scale, hence PIX_LAT+2.
    logic [2:0] sync_in;
    logic [2:0] sync_out;

    assign sync_in = {hsync_in, vsync_in, blank_in};

    sync_delay_line #(
        .WIDTH  (3),
        .DEPTH  (PIX_LAT + 2),
        .RST_VAL({SYNC_IDLE, SYNC_IDLE, BLANK_IDLE})
    ) u_sync_delay (
        .clk  (clk),
        .reset(reset),
        .d_i  (sync_in),
        .q_o  (sync_out)
    );

    assign hsync_out = sync_out[2];
    assign vsync_out = sync_out[1];
    assign blank_out = sync_out[0];

    // ---------------------------------------------------------------- stage 1: mix
    logic [COLOR_W-1:0] mix_d;
    logic [COLOR_W-1:0] mix_q;
    logic [9:0]         ch_sum;
    logic               any_lit;

    always_comb begin
        mix_d   = '0;
        ch_sum  = '0;
        any_lit = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_sum = '0;
            for (int l = 0; l < NUM_LAYERS; l++) begin
                if (layer_en[l]) begin
                    ch_sum = ch_sum + {2'b00, layer_pix[l*COLOR_W + c*CH_W +: CH_W]};
                end
            end
            mix_d[c*CH_W +: CH_W] = sat_ch(ch_sum);
        end
        for (int l = 0; l < NUM_LAYERS; l++) begin
            if (layer_en[l] && (layer_pix[l*COLOR_W +: COLOR_W] != '0)) begin
                any_lit = 1'b1;
            end
        end
        // Nothing lit (or nothing enabled): show the background.
        if (!any_lit) begin
            mix_d = BG_COLOR;
        end
    end

    // ---------------------------------------------------------------- stage 2: scale
    logic [COLOR_W-1:0] scale_d;
    logic [COLOR_W-1:0] scale_q;
    logic [CH_W-1:0]    bright_q;

    always_comb begin
        scale_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            scale_d[c*CH_W +: CH_W] = scale_ch(mix_q[c*CH_W +: CH_W], bright_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mix_q   <= '0;
            scale_q <= '0;
        end else begin
            mix_q   <= mix_d;
            scale_q <= scale_d;
        end
    end

    // blank_out is the registered blank tap that lines up with scale_q, so
    // masking after the flops keeps blanking exact without an extra tap.
    assign rgb_out = blank_out ? '0 : scale_q;

    // ---------------------------------------------------------------- frame tick
    logic vs_q;
    logic tick;

    assign tick = vs_q & ~vsync_in;   // vsync falling edge, one cycle wide

    // ---------------------------------------------------------------- brightness FSM
    br_state_e       state_q;
    br_state_e       state_d;
    logic [CH_W-1:0] bright_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BR_IDLE;
            bright_q <= BRIGHT_MAX;
            vs_q     <= SYNC_IDLE;
        end else begin
            state_q  <= state_d;
            bright_q <= bright_d;
            vs_q     <= vsync_in;
        end
    end

    // Next state: a tick always consumes the pending beat (a beat on the tick
    // cycle itself is consumed by the same tick).
    always_comb begin
        state_d = state_q;
        if (tick) begin
            state_d = BR_IDLE;
        end else if (beat) begin
            state_d = BR_PENDING;
        end
    end

    // Outputs: brightness only moves on a tick.
    always_comb begin
        bright_d = bright_q;
        if (tick) begin
            if ((state_q == BR_PENDING) || beat) begin
                bright_d = BRIGHT_MAX;
            end else if ({1'b0, bright_q} < FLOOR_THR) begin
                bright_d = MIN_B;
            end else begin
                bright_d = bright_q - DECAY_B;
            end
        end
    end

    assign brightness  = bright_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_circle_layer_mixer.sv
module tb_circle_layer_mixer;
    import circle_layer_mixer_pkg::*;

    // ------------------------------------------------ clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        hsync_in, vsync_in, blank_in, beat;
    logic [95:0] layer_pix;
    logic [3:0]  layer_en;
    logic [23:0] rgb_out;
    logic        hsync_out, vsync_out, blank_out;
    logic [7:0]  brightness;
    br_state_e   dbg_state_o;

    circle_layer_mixer #(
        .NUM_LAYERS(4),
        .PIX_LAT   (3),
        .DECAY     (8),
        .MIN_BRIGHT(32),
        .BG_COLOR  (24'h000040)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .blank_in   (blank_in),
        .layer_pix  (layer_pix),
        .layer_en   (layer_en),
        .beat       (beat),
        .rgb_out    (rgb_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .blank_out  (blank_out),
        .brightness (brightness),
        .dbg_state_o(dbg_state_o)
    );

    // cyc counts rising edges; inputs driven 1 ns after edge cyc are first
    // sampled at edge cyc+1, and a value N flops deep shows at cyc+N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------ scoreboard
    localparam int K_RGB = 0, K_HS = 1, K_VS = 2, K_BL = 3, K_BR = 4, K_ST = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [23:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic string kname(input int k);
        case (k)
            K_RGB:   return "rgb_out";
            K_HS:    return "hsync_out";
            K_VS:    return "vsync_out";
            K_BL:    return "blank_out";
            K_BR:    return "brightness";
            default: return "fsm_state";
        endcase
    endfunction

    function automatic logic [23:0] actual(input int k);
        case (k)
            K_RGB:   return rgb_out;
            K_HS:    return {23'd0, hsync_out};
            K_VS:    return {23'd0, vsync_out};
            K_BL:    return {23'd0, blank_out};
            K_BR:    return {16'd0, brightness};
            default: return 24'(dbg_state_o);
        endcase
    endfunction

    // Monitor: samples on the falling edge, pops every expectation due now.
    int          mon_i;
    logic [23:0] mon_act;
    always @(negedge clk) begin
        mon_i = 0;
        while (mon_i < exp_q.size()) begin
            if (exp_q[mon_i].cyc == cyc) begin
                mon_act = actual(exp_q[mon_i].kind);
                checks++;
                if (mon_act !== exp_q[mon_i].val) begin
                    errors++;
                    $display("FAIL %s @cycle %0d: got %h expected %h",
                             kname(exp_q[mon_i].kind), cyc, mon_act, exp_q[mon_i].val);
                end
                exp_q.delete(mon_i);
            end else if (exp_q[mon_i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s @cycle %0d: check never sampled",
                         kname(exp_q[mon_i].kind), exp_q[mon_i].cyc);
                exp_q.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
    end

    // ------------------------------------------------ driver tasks
    logic [7:0] model_br;
    logic       pending;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dly, input int kind, input logic [23:0] val);
        exp_t e;
        e.cyc  = cyc + dly;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] decayed(input logic [7:0] b);
        return (b < 8'd40) ? 8'd32 : b - 8'd8;
    endfunction

    // One vsync falling edge; optionally a beat on the tick cycle itself.
    task automatic vsync_fall(input logic beat_on_tick);
        logic [7:0] nb;
        nb = (pending || beat_on_tick) ? 8'hFF : decayed(model_br);
        expect_at(0, K_BR, {16'd0, model_br});
        vsync_in = 1'b0;
        beat     = beat_on_tick;
        expect_at(1, K_BR, {16'd0, nb});
        expect_at(1, K_ST, 24'(BR_IDLE));
        step(1);
        beat = 1'b0;
        step(2);
        vsync_in = 1'b1;
        step(3);
        model_br = nb;
        pending  = 1'b0;
    endtask

    task automatic beat_pulse();
        beat = 1'b1;
        step(1);
        beat    = 1'b0;
        pending = 1'b1;
        expect_at(0, K_ST, 24'(BR_PENDING));
        expect_at(0, K_BR, {16'd0, model_br});
    endtask

    // ------------------------------------------------ stimulus
    initial begin
        reset     = 1'b1;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        blank_in  = 1'b1;
        beat      = 1'b0;
        layer_pix = '0;
        layer_en  = '0;
        model_br  = 8'hFF;
        pending   = 1'b0;

        // Reset values after 4 reset cycles
        step(4);
        expect_at(0, K_RGB, 24'h0);
        expect_at(0, K_HS, 24'h1);
        expect_at(0, K_VS, 24'h1);
        expect_at(0, K_BL, 24'h1);
        expect_at(0, K_BR, 24'hFF);
        expect_at(0, K_ST, 24'(BR_IDLE));
        step(1);
        reset = 1'b0;
        step(6);

        // Latency: hsync/blank fall at cycle 0, pixel at cycle 3
        hsync_in = 1'b0;
        blank_in = 1'b0;
        layer_en = 4'b0001;
        expect_at(4, K_HS, 24'h1);
        expect_at(5, K_HS, 24'h0);
        expect_at(5, K_BL, 24'h0);
        expect_at(4, K_RGB, 24'h0);
        step(3);
        layer_pix[23:0] = 24'h102030;
        expect_at(2, K_RGB, 24'h102030);
        step(3);
        hsync_in = 1'b1;
        step(6);

        // Saturation; layer 2/3 carry colour but stay disabled
        layer_pix = {24'hFFFFFF, 24'h00FF00, 24'h80A010, 24'hC08010};
        layer_en  = 4'b0011;
        expect_at(2, K_RGB, 24'hFFFF20);
        step(4);
        layer_en = 4'b0001;
        expect_at(2, K_RGB, 24'hC08010);
        step(4);

        // Background: nothing enabled, then all enabled layers zero
        layer_en = 4'b0000;
        expect_at(2, K_RGB, 24'h000040);
        step(4);
        layer_en  = 4'b1111;
        layer_pix = '0;
        expect_at(2, K_RGB, 24'h000040);
        step(4);

        // Blank forces black exactly PIX_LAT+2 after blank_in
        layer_en        = 4'b0001;
        layer_pix[23:0] = 24'h102030;
        blank_in        = 1'b1;
        expect_at(4, K_RGB, 24'h102030);
        expect_at(5, K_RGB, 24'h0);
        expect_at(6, K_BL, 24'h1);
        step(8);
        blank_in = 1'b0;
        expect_at(4, K_RGB, 24'h0);
        expect_at(5, K_RGB, 24'h102030);
        step(8);

        // Decay: first fall also checks vsync_out latency
        expect_at(4, K_VS, 24'h1);
        expect_at(5, K_VS, 24'h0);
        vsync_fall(1'b0);   // 247
        vsync_fall(1'b0);   // 239
        vsync_fall(1'b0);   // 231
        for (int f = 3; f < 16; f++) vsync_fall(1'b0);   // -> 127
        layer_pix       = '0;
        layer_pix[23:0] = 24'h808080;
        expect_at(0, K_BR, 24'h00007F);
        expect_at(2, K_RGB, 24'h404040);
        step(4);
        for (int f = 16; f < 40; f++) vsync_fall(1'b0);  // floor reached
        expect_at(0, K_BR, 24'h000020);
        vsync_fall(1'b0);   // holds at 32

        // Beat mid-frame: no change until the tick, then full; then decay resumes
        beat_pulse();
        step(5);
        expect_at(0, K_BR, 24'h000020);
        vsync_fall(1'b0);   // 255
        vsync_fall(1'b0);   // 247

        // Two beats in one frame act as one
        beat_pulse();
        step(3);
        beat_pulse();
        vsync_fall(1'b0);   // 255
        vsync_fall(1'b0);   // 247

        // Beat on the tick cycle itself
        vsync_fall(1'b1);   // 255
        vsync_fall(1'b0);   // 247

        // Reset mid-frame clears brightness, pending beat and sync taps
        beat_pulse();
        hsync_in = 1'b0;
        step(6);
        expect_at(0, K_HS, 24'h0);
        reset = 1'b1;
        step(1);
        expect_at(0, K_HS, 24'h1);
        expect_at(0, K_BL, 24'h1);
        expect_at(0, K_RGB, 24'h0);
        expect_at(0, K_BR, 24'hFF);
        expect_at(0, K_ST, 24'(BR_IDLE));
        reset = 1'b0;
        expect_at(4, K_HS, 24'h1);
        expect_at(5, K_HS, 24'h0);
        step(8);
        hsync_in = 1'b1;
        model_br = 8'hFF;
        pending  = 1'b0;
        step(3);
        vsync_fall(1'b0);   // 247: the pre-reset beat is gone

        // Drain
        step(10);
        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s @cycle %0d: left in queue", kname(exp_q[0].kind), exp_q[0].cyc);
            void'(exp_q.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
